alu_operand_stage: RTL
======================

# alu_operand_stage

Registered, parametrised ALU operand selection stage between register-file read and the ALU in the pipelined core. It selects operand pairs for register, immediate and shift instruction forms and forwards in-flight results from the EX and MEM stages. It detects load-use hazards and holds upstream, and presents the operand pair through a valid/ready pipeline register with one-cycle latency.

## Interface
- WIDTH, 32, datapath word width (≥ 8)
- SHAMT_W, 5, shift-amount width (< WIDTH)
- REG_AW, 5, register address width

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream operands valid
- in_ready  out  1  stage accepts this cycle
- alu_src  in  2  00 R-form, 01 I-form, 11 shift, 10 illegal
- rs_addr, rt_addr  in  REG_AW  source register numbers
- rs_data, rt_data  in  WIDTH  register-file read data
- ext_imm  in  WIDTH  extended immediate
- shamt  in  SHAMT_W  shift amount
- ex_wr_en, mem_wr_en  in  1  EX/MEM stage will write a register
- ex_wr_addr, mem_wr_addr  in  REG_AW  destination numbers
- ex_wr_data, mem_wr_data  in  WIDTH  result values
- ex_is_load  in  1  EX instruction is a load (data not yet available)
- out_valid  out  1  operand pair valid
- out_ready  in  1  ALU accepts
- alu_a, alu_b  out  WIDTH  registered operands
- hazard_stall  out  1  load-use stall active (combinational)
- illegal_err  out  1  sticky: alu_src=10 was accepted
- illegal_cnt  out  8  saturating count of illegal accepts

## Operation
- Source resolution for rs and rt independently: EX match (ex_wr_en, addr equal, addr≠0) wins, then MEM match, else register-file data. Register 0 is never forwarded and resolves to rs_data/rt_data.
- Used sources: 00 → rs, rt; 01 → rs; 11 → rt; 10 → none.
- Operand mux: 00 → a=rs', b=rt'; 01 → a=rs', b=ext_imm; 11 → a=rt', b=shamt zero-extended to WIDTH; 10 → a=b=0, illegal_err set, illegal_cnt +1 saturating at 255.
- hazard_stall = in_valid & ex_is_load & ex_wr_en & ex_wr_addr≠0 & ex_wr_addr equals a used source.
- in_ready = ~hazard_stall & (~out_valid | out_ready).
- Capture when in_valid & in_ready: alu_a/alu_b/out_valid load next edge. If out_valid & out_ready with no capture, out_valid clears. alu_a/alu_b hold when not capturing.
- Held output (out_valid & ~out_ready) is stable; later forwarding changes do not alter it.

## Timing
- Reset (async, immediate): out_valid=0, alu_a=alu_b=0, illegal_err=0, illegal_cnt=0. Reset mid-transfer discards the held pair.
- Latency 1 cycle from accept to out_valid; throughput 1/cycle with out_ready high.
- Forwarding and hazard decode are combinational on the cycle of accept. Forwarded data is sampled at the capture edge.
- Simultaneous drain and capture: the new pair replaces the old with out_valid remaining 1.
- Hazard has priority over ready; a stalled beat is not captured and illegal_cnt is not incremented.

## Configuration
- ALU_FWD_EN defined: forwarding as above.
- ALU_FWD_EN undefined: no forwarding. Operands are always register-file data. hazard_stall asserts on any EX or MEM write match (addr≠0) to a used source, regardless of ex_is_load.

## Test plan
- R-form, rs=3 (0x10), rt=4 (0x20), no writers, out_ready=1 → next cycle out_valid=1, a=0x10, b=0x20.
- ex_wr (addr 3, 0xAA) and mem_wr (addr 3, 0xBB), I-form imm=0x5 → a=0xAA, b=0x5; repeat with rs=0 → a=rs_data.
- Shift, rt=7, ex_is_load writing 7 → hazard_stall=1, in_ready=0 for 2 cycles. Drop load → capture a=rt', b=shamt.
- out_ready=0 for 3 cycles after capture → alu_a/alu_b stable, in_ready=0. Release → drain and accept next beat the same cycle.
- alu_src=10 accepted 260 times → a=b=0, illegal_err=1, illegal_cnt=255. Assert rst mid-run → all outputs 0 immediately.
- ALU_FWD_EN undefined build: MEM write match on rs, R-form → hazard_stall=1 until match removed; then a=rs_data.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ALU operand stage: it selects the operands, forwards results from EX/MEM, stalls on a
// load-use hazard, and registers the operand pair behind valid/ready. Define ALU_FWD_EN to enable forwarding.
module alu_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int REG_AW  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_src,
    input  logic [REG_AW-1:0]  rs_addr,
    input  logic [REG_AW-1:0]  rt_addr,
    input  logic [WIDTH-1:0]   rs_data,
    input  logic [WIDTH-1:0]   rt_data,
    input  logic [WIDTH-1:0]   ext_imm,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               ex_wr_en,
    input  logic [REG_AW-1:0]  ex_wr_addr,
    input  logic [WIDTH-1:0]   ex_wr_data,
    input  logic               mem_wr_en,
    input  logic [REG_AW-1:0]  mem_wr_addr,
    input  logic [WIDTH-1:0]   mem_wr_data,
    input  logic               ex_is_load,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               hazard_stall,
    output logic               illegal_err,
    output logic [7:0]         illegal_cnt
);

    typedef enum logic [1:0] {
        SRC_R     = 2'b00,
        SRC_I     = 2'b01,
        SRC_ILL   = 2'b10,
        SRC_SHIFT = 2'b11
    } src_e;

    src_e src;
    logic use_rs, use_rt;
    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic [WIDTH-1:0] rs_val, rt_val;
    logic [WIDTH-1:0] op_a, op_b;
    logic is_illegal, accept;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic             illegal_err_q, illegal_err_d;
    logic [7:0]       illegal_cnt_q, illegal_cnt_d;

    assign src = src_e'(alu_src);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        case (src)
            SRC_R:     begin use_rs = 1'b1; use_rt = 1'b1; end
            SRC_I:     use_rs = 1'b1;
            SRC_SHIFT: use_rt = 1'b1;
            default:   ;
        endcase
    end

    // Register 0 is hardwired, so a write aimed at it never matches a source.
    assign ex_hit_rs  = ex_wr_en  && (ex_wr_addr  == rs_addr) && (rs_addr != '0);
    assign ex_hit_rt  = ex_wr_en  && (ex_wr_addr  == rt_addr) && (rt_addr != '0);
    assign mem_hit_rs = mem_wr_en && (mem_wr_addr == rs_addr) && (rs_addr != '0);
    assign mem_hit_rt = mem_wr_en && (mem_wr_addr == rt_addr) && (rt_addr != '0);

`ifdef ALU_FWD_EN
    always_comb begin
        rs_val = rs_data;
        rt_val = rt_data;
        if (ex_hit_rs)       rs_val = ex_wr_data;
        else if (mem_hit_rs) rs_val = mem_wr_data;
        if (ex_hit_rt)       rt_val = ex_wr_data;
        else if (mem_hit_rt) rt_val = mem_wr_data;
    end

    // Only a load in EX is unresolvable; every other producer is forwarded.
    assign hazard_stall = in_valid & ex_is_load &
                          ((use_rs & ex_hit_rs) | (use_rt & ex_hit_rt));
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_wr_data, mem_wr_data, ex_is_load};

    assign rs_val = rs_data;
    assign rt_val = rt_data;

    // Without forwarding, any pending write to a used source must retire first.
    assign hazard_stall = in_valid &
                          ((use_rs & (ex_hit_rs | mem_hit_rs)) |
                           (use_rt & (ex_hit_rt | mem_hit_rt)));
`endif

    always_comb begin
        op_a       = '0;
        op_b       = '0;
        is_illegal = 1'b0;
        case (src)
            SRC_R:     begin op_a = rs_val; op_b = rt_val;        end
            SRC_I:     begin op_a = rs_val; op_b = ext_imm;       end
            SRC_SHIFT: begin op_a = rt_val; op_b = WIDTH'(shamt); end
            default:   is_illegal = 1'b1;
        endcase
    end

    assign in_ready = ~hazard_stall & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        illegal_err_d = illegal_err_q;
        illegal_cnt_d = illegal_cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            alu_a_d     = op_a;
            alu_b_d     = op_b;
            if (is_illegal) begin
                illegal_err_d = 1'b1;
                if (illegal_cnt_q != 8'hFF) illegal_cnt_d = illegal_cnt_q + 8'd1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            illegal_err_q <= 1'b0;
            illegal_cnt_q <= 8'd0;
        end else begin
            out_valid_q   <= out_valid_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            illegal_err_q <= illegal_err_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign illegal_err = illegal_err_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule
